// File: rtl/fpu_control.sv
// fpu_control
//   Registered decoder for the double-precision arithmetic/convert subset of
//   the RV64D OP-FP major opcode. It sits between instruction decode and the
//   FPU datapath. One instruction is accepted every cycle, and every output is
//   registered, so results appear one clock after the instruction.
//
//   Optional feature: when the macro FPU_SINGLE_EN is defined, fmt=00
//   (single precision) is also accepted for the same seven operations, and
//   fmt_single flags those instructions. Without the macro, fmt=00 is illegal
//   and fmt_single is always 0.
//
// Parameters
//   OP_W        width of fpu_op (the encoding is fixed at 3 bits)
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   instr_valid instruction qualifier
//   instruction raw 32-bit RISC-V instruction word
//   fpu_op      decoded operation (3'b111 = none)
//   op_valid    a legal, supported FP operation was decoded
//   illegal     instr_valid was high but the instruction is not supported
//   rd          instruction[11:7]
//   rs1         instruction[19:15]
//   rs2         instruction[24:20]
//   rm          instruction[14:12]
//   int_dst     result goes to the integer register file (fcvt.l.d)
//   int_src     rs1 is read from the integer register file (fcvt.d.l)
//   fmt_single  single-precision operation (only with FPU_SINGLE_EN)
module fpu_control #(
  parameter int unsigned OP_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instruction,
  output logic [OP_W-1:0] fpu_op,
  output logic            op_valid,
  output logic            illegal,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      rm,
  output logic            int_dst,
  output logic            int_src,
  output logic            fmt_single
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_SQRT = 3'b100,
    OP_CVTLD = 3'b101,
    OP_CVTDL = 3'b110,
    OP_NONE = 3'b111
  } fpu_op_e;

  localparam logic [6:0] OPCODE_OP_FP = 7'b1010011;

  // Instruction fields
  logic [6:0] f_opcode;
  logic [2:0] f_rm;
  logic [4:0] f_rs2;
  logic [1:0] f_fmt;
  logic [4:0] f_funct5;

  assign f_opcode = instruction[6:0];
  assign f_rm     = instruction[14:12];
  assign f_rs2    = instruction[24:20];
  assign f_fmt    = instruction[26:25];
  assign f_funct5 = instruction[31:27];

  // Combinational decode, registered below
  fpu_op_e dec_op;
  logic    dec_legal;
  logic    dec_int_dst;
  logic    dec_int_src;
  logic    dec_single;
  logic    fmt_ok;
  logic    fmt_is_single;
  logic    rm_ok;

  always_comb begin
    fmt_is_single = 1'b0;
`ifdef FPU_SINGLE_EN
    fmt_ok        = (f_fmt == 2'b01) || (f_fmt == 2'b00);
    fmt_is_single = (f_fmt == 2'b00);
`else
    fmt_ok        = (f_fmt == 2'b01);
`endif
    // rm 101 and 110 are reserved; 111 selects the dynamic mode
    rm_ok = (f_rm <= 3'b100) || (f_rm == 3'b111);
  end

  always_comb begin
    dec_op      = OP_NONE;
    dec_legal   = 1'b0;
    dec_int_dst = 1'b0;
    dec_int_src = 1'b0;
    dec_single  = 1'b0;

    if ((f_opcode == OPCODE_OP_FP) && fmt_ok && rm_ok) begin
      unique case (f_funct5)
        5'b00000: begin
          dec_op    = OP_ADD;
          dec_legal = 1'b1;
        end
        5'b00001: begin
          dec_op    = OP_SUB;
          dec_legal = 1'b1;
        end
        5'b00010: begin
          dec_op    = OP_MUL;
          dec_legal = 1'b1;
        end
        5'b00011: begin
          dec_op    = OP_DIV;
          dec_legal = 1'b1;
        end
        5'b01011: begin
          if (f_rs2 == 5'b00000) begin
            dec_op    = OP_SQRT;
            dec_legal = 1'b1;
          end
        end
        5'b11000: begin
          if (f_rs2 == 5'b00010) begin
            dec_op      = OP_CVTLD;
            dec_legal   = 1'b1;
            dec_int_dst = 1'b1;
          end
        end
        5'b11010: begin
          if (f_rs2 == 5'b00010) begin
            dec_op      = OP_CVTDL;
            dec_legal   = 1'b1;
            dec_int_src = 1'b1;
          end
        end
        default: begin
          dec_op    = OP_NONE;
          dec_legal = 1'b0;
        end
      endcase
      dec_single = dec_legal & fmt_is_single;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpu_op     <= '1;
      op_valid   <= 1'b0;
      illegal    <= 1'b0;
      int_dst    <= 1'b0;
      int_src    <= 1'b0;
      fmt_single <= 1'b0;
      rd         <= '0;
      rs1        <= '0;
      rs2        <= '0;
      rm         <= '0;
    end else begin
      // Register fields are captured every cycle regardless of legality
      rd  <= instruction[11:7];
      rs1 <= instruction[19:15];
      rs2 <= instruction[24:20];
      rm  <= instruction[14:12];
      if (instr_valid && dec_legal) begin
        fpu_op     <= OP_W'(dec_op);
        op_valid   <= 1'b1;
        illegal    <= 1'b0;
        int_dst    <= dec_int_dst;
        int_src    <= dec_int_src;
        fmt_single <= dec_single;
      end else begin
        fpu_op     <= '1;
        op_valid   <= 1'b0;
        illegal    <= instr_valid;
        int_dst    <= 1'b0;
        int_src    <= 1'b0;
        fmt_single <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_control.sv
// tb_fpu_control
//   Directed testbench for fpu_control. Inputs are driven on the falling edge
//   and outputs are checked on the following falling edge, i.e. one rising
//   edge after the instruction was presented.
module tb_fpu_control;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [2:0]  fpu_op;
  logic        op_valid;
  logic        illegal;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  rm;
  logic        int_dst;
  logic        int_src;
  logic        fmt_single;

  int checks;
  int errors;

  fpu_control #(.OP_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .fpu_op      (fpu_op),
    .op_valid    (op_valid),
    .illegal     (illegal),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rm          (rm),
    .int_dst     (int_dst),
    .int_src     (int_src),
    .fmt_single  (fmt_single)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the decode outputs (fields are checked separately where known)
  task automatic chk_dec(input string tag, input logic [2:0] e_op, input logic e_ov,
                         input logic e_ill, input logic e_idst, input logic e_isrc,
                         input logic e_single);
    chk({tag, ".fpu_op"},     32'(fpu_op),     32'(e_op));
    chk({tag, ".op_valid"},   32'(op_valid),   32'(e_ov));
    chk({tag, ".illegal"},    32'(illegal),    32'(e_ill));
    chk({tag, ".int_dst"},    32'(int_dst),    32'(e_idst));
    chk({tag, ".int_src"},    32'(int_src),    32'(e_isrc));
    chk({tag, ".fmt_single"}, 32'(fmt_single), 32'(e_single));
  endtask

  task automatic chk_fields(input string tag, input logic [4:0] e_rd, input logic [4:0] e_rs1,
                            input logic [4:0] e_rs2, input logic [2:0] e_rm);
    chk({tag, ".rd"},  32'(rd),  32'(e_rd));
    chk({tag, ".rs1"}, 32'(rs1), 32'(e_rs1));
    chk({tag, ".rs2"}, 32'(rs2), 32'(e_rs2));
    chk({tag, ".rm"},  32'(rm),  32'(e_rm));
  endtask

  // Present one instruction and wait one full cycle
  task automatic step(input logic [31:0] w, input logic v);
    instruction = w;
    instr_valid = v;
    @(negedge clk);
  endtask

  logic [31:0] stream_w [7];
  logic [2:0]  stream_op [7];

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instruction = 32'h0;

    stream_w[0] = 32'h023170d3; stream_op[0] = 3'b000;
    stream_w[1] = 32'h0ada75d3; stream_op[1] = 3'b001;
    stream_w[2] = 32'h1293fad3; stream_op[2] = 3'b010;
    stream_w[3] = 32'h1af87f53; stream_op[3] = 3'b011;
    stream_w[4] = 32'h5a01fbd3; stream_op[4] = 3'b100;
    stream_w[5] = 32'hc225f9d3; stream_op[5] = 3'b101;
    stream_w[6] = 32'hd2267dd3; stream_op[6] = 3'b110;

    @(negedge clk);
    @(negedge clk);
    chk_dec("reset", 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fields("reset", 5'd0, 5'd0, 5'd0, 3'd0);
    rst_n = 1'b1;

    // Arithmetic ops
    step(32'h023170d3, 1'b1);
    chk_dec("fadd", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fields("fadd", 5'd1, 5'd2, 5'd3, 3'b111);
    step(32'h0ada75d3, 1'b1);
    chk_dec("fsub", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fields("fsub", 5'd11, 5'd20, 5'd13, 3'b111);
    step(32'h1293fad3, 1'b1);
    chk_dec("fmul", 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fmul.rd", 32'(rd), 32'd21);
    step(32'h1af87f53, 1'b1);
    chk_dec("fdiv", 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fdiv.rd", 32'(rd), 32'd30);
    step(32'h5a01fbd3, 1'b1);
    chk_dec("fsqrt", 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fields("fsqrt", 5'd23, 5'd3, 5'd0, 3'b111);

    // Converts
    step(32'hc225f9d3, 1'b1);
    chk_dec("fcvt_l_d", 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_fields("fcvt_l_d", 5'd19, 5'd11, 5'd2, 3'b111);
    step(32'hd2267dd3, 1'b1);
    chk_dec("fcvt_d_l", 3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_fields("fcvt_d_l", 5'd27, 5'd12, 5'd2, 3'b111);

    // Illegal cases
    step(32'hF8000000, 1'b1);
    chk_dec("ill_opcode", 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h023150d3, 1'b1);
    chk_dec("ill_rm101", 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ill_rm101.rm", 32'(rm), 32'b101);
    step(32'h023160d3, 1'b1);
    chk_dec("ill_rm110", 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h023100d3, 1'b1);
    chk_dec("fadd_rm000", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h023140d3, 1'b1);
    chk_dec("fadd_rm100", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h5a11fbd3, 1'b1);
    chk_dec("ill_sqrt_rs2", 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ill_sqrt_rs2.rs2", 32'(rs2), 32'd1);
    step(32'hc235f9d3, 1'b1);
    chk_dec("ill_cvt_rs2", 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h063170d3, 1'b1);
    chk_dec("ill_fmt11", 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h043170d3, 1'b1);
    chk_dec("ill_fmt10", 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h223170d3, 1'b1);
    chk_dec("ill_funct5", 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h003100d3, 1'b1);
`ifdef FPU_SINGLE_EN
    chk_dec("fadd_s", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    chk_dec("fadd_s", 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // Qualifier low with a legal word: fields still captured
    step(32'h023170d3, 1'b0);
    chk_dec("novalid", 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fields("novalid", 5'd1, 5'd2, 5'd3, 3'b111);

    // Reset wins over a simultaneous fdiv
    step(32'hc225f9d3, 1'b1);
    chk("pre_reset.int_dst", 32'(int_dst), 32'd1);
    rst_n = 1'b0;
    step(32'h1af87f53, 1'b1);
    chk_dec("reset_fdiv", 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fields("reset_fdiv", 5'd0, 5'd0, 5'd0, 3'd0);
    rst_n = 1'b1;

    // Throughput: all seven legal ops back to back
    for (int i = 0; i < 7; i++) begin
      step(stream_w[i], 1'b1);
      chk($sformatf("stream%0d.fpu_op", i), 32'(fpu_op), 32'(stream_op[i]));
      chk($sformatf("stream%0d.op_valid", i), 32'(op_valid), 32'd1);
    end
    step(32'h0, 1'b0);
    chk("stream_end.op_valid", 32'(op_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
